// File: rtl/gbt_rx_pattern_checker_pkg.sv
// Shared types and default constants for the GBT receive-side pattern checker.
package MCPkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } gbt_chk_state_t;

    localparam int GBT_CHK_LOCK_FRAMES = 4;
    localparam int GBT_CHK_LOSS_ERRORS = 3;

endpackage

// File: rtl/gbt_rx_pattern_checker_sat_counter.sv
// Saturating incrementer with synchronous clear; a clear coinciding with an
// increment leaves the count at 1.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/gbt_rx_pattern_checker.sv
// Checks the incrementing {n, n} motor-data pattern on the GBT receive side,
// tracking lock, per-frame error strobes and link statistics.
module gbt_rx_pattern_checker
    import MCPkg::*;
#(
    parameter int LOCK_FRAMES = GBT_CHK_LOCK_FRAMES,
    parameter int LOSS_ERRORS = GBT_CHK_LOSS_ERRORS,
    parameter int CNT_W       = 16
) (
    input  ckrs_t              ClkRs_ix,
    input  logic               rx_ready_i,
    input  logic               rx_valid_i,
    input  logic [63:0]        rx_data_i,
    input  logic               clear_i,
    output logic               locked_o,
    output logic               error_o,
    output logic [CNT_W-1:0]   error_count_o,
    output logic [31:0]        frame_count_o,
    output logic [31:0]        expected_o,
    output logic [63:0]        last_bad_o
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [7:0] LOSS_N = 8'(LOSS_ERRORS);

    logic           clk;
    logic           rst;
    gbt_chk_state_t state;
    logic [7:0]     good_run;
    logic [7:0]     bad_run;
    logic [7:0]     good_run_inc;
    logic [7:0]     bad_run_inc;
    logic [31:0]    rx_hi;
    logic [31:0]    rx_lo;
    logic           sampled;
    logic           halves_eq;
    logic           is_good;
    logic           err_pulse;

    assign clk          = ClkRs_ix.clk;
    assign rst          = ClkRs_ix.reset;
    assign rx_hi        = rx_data_i[63:32];
    assign rx_lo        = rx_data_i[31:0];
    assign sampled      = rx_valid_i && rx_ready_i;
    assign halves_eq    = (rx_hi == rx_lo);
    assign is_good      = halves_eq && (rx_hi == expected_o);
    assign good_run_inc = good_run + 8'd1;
    assign bad_run_inc  = bad_run + 8'd1;
    assign err_pulse    = sampled && !is_good &&
                          ((state == VERIFY) || (state == LOCKED));

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_error_count (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_i),
        .inc   (err_pulse),
        .count (error_count_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            locked_o      <= 1'b0;
            error_o       <= 1'b0;
            good_run      <= '0;
            bad_run       <= '0;
            expected_o    <= '0;
            frame_count_o <= '0;
            last_bad_o    <= '0;
        end else begin
            error_o <= err_pulse;

            // Clear takes effect first, then the current frame is counted.
            if (clear_i) begin
                frame_count_o <= {31'd0, sampled};
            end else if (sampled) begin
                frame_count_o <= frame_count_o + 32'd1;
            end

            if (err_pulse) begin
                last_bad_o <= rx_data_i;
            end else if (clear_i) begin
                last_bad_o <= '0;
            end

            if (!rx_ready_i) begin
                state    <= IDLE;
                locked_o <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
            end else begin
                case (state)
                    // A frame arriving as the link comes ready is treated as a seek candidate.
                    IDLE, SEEK: begin
                        state <= SEEK;
                        if (sampled && halves_eq) begin
                            expected_o <= rx_hi + 32'd1;
                            good_run   <= 8'd1;
                            bad_run    <= '0;
                            if (LOCK_N <= 8'd1) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end else if (sampled) begin
                            expected_o <= expected_o + 32'd1;
                        end
                    end
                    VERIFY: begin
                        if (sampled) begin
                            expected_o <= expected_o + 32'd1;
                            if (is_good) begin
                                good_run <= good_run_inc;
                                if (good_run_inc >= LOCK_N) begin
                                    state    <= LOCKED;
                                    locked_o <= 1'b1;
                                    bad_run  <= '0;
                                end
                            end else begin
                                state    <= SEEK;
                                good_run <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (sampled) begin
                            expected_o <= expected_o + 32'd1;
                            if (is_good) begin
                                bad_run <= '0;
                            end else if (bad_run_inc >= LOSS_N) begin
                                state    <= SEEK;
                                locked_o <= 1'b0;
                                bad_run  <= '0;
                                good_run <= '0;
                            end else begin
                                bad_run <= bad_run_inc;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gbt_rx_pattern_checker.sv
// Directed bench for gbt_rx_pattern_checker: default-parameter instance plus a
// narrow-counter, single-frame-lock instance for saturation and clear.
module tb_gbt_rx_pattern_checker;
    import MCPkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    ckrs_t clkrs;
    assign clkrs = {clk, rst};

    always #12 clk = ~clk;

    logic        ready_a = 1'b0, valid_a = 1'b0, clear_a = 1'b0;
    logic [63:0] data_a  = '0;
    logic        locked_a, error_a;
    logic [15:0] errcnt_a;
    logic [31:0] frmcnt_a, exp_a;
    logic [63:0] lastbad_a;

    logic        ready_b = 1'b0, valid_b = 1'b0, clear_b = 1'b0;
    logic [63:0] data_b  = '0;
    logic        locked_b, error_b;
    logic [3:0]  errcnt_b;
    logic [31:0] frmcnt_b, exp_b;
    logic [63:0] lastbad_b;

    gbt_rx_pattern_checker u_dut_a (
        .ClkRs_ix      (clkrs),
        .rx_ready_i    (ready_a),
        .rx_valid_i    (valid_a),
        .rx_data_i     (data_a),
        .clear_i       (clear_a),
        .locked_o      (locked_a),
        .error_o       (error_a),
        .error_count_o (errcnt_a),
        .frame_count_o (frmcnt_a),
        .expected_o    (exp_a),
        .last_bad_o    (lastbad_a)
    );

    gbt_rx_pattern_checker #(
        .LOCK_FRAMES (1),
        .LOSS_ERRORS (255),
        .CNT_W       (4)
    ) u_dut_b (
        .ClkRs_ix      (clkrs),
        .rx_ready_i    (ready_b),
        .rx_valid_i    (valid_b),
        .rx_data_i     (data_b),
        .clear_i       (clear_b),
        .locked_o      (locked_b),
        .error_o       (error_b),
        .error_count_o (errcnt_b),
        .frame_count_o (frmcnt_b),
        .expected_o    (exp_b),
        .last_bad_o    (lastbad_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_a(input logic [31:0] hi, input logic [31:0] lo);
        valid_a = 1'b1;
        data_a  = {hi, lo};
        tick();
        valid_a = 1'b0;
    endtask

    task automatic frame_b(input logic [31:0] hi, input logic [31:0] lo);
        valid_b = 1'b1;
        data_b  = {hi, lo};
        tick();
        valid_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_locked", 64'(locked_a), 64'd0);
        check("rst_expected", 64'(exp_a), 64'd0);
        check("rst_errcnt", 64'(errcnt_a), 64'd0);
        check("rst_frmcnt", 64'(frmcnt_a), 64'd0);
        check("rst_lastbad", lastbad_a, 64'd0);

        // Lock acquisition
        ready_a = 1'b1;
        tick();
        frame_a(5, 5);
        frame_a(6, 6);
        frame_a(7, 7);
        check("lock_before_4th", 64'(locked_a), 64'd0);
        frame_a(8, 8);
        check("lock_after_4th", 64'(locked_a), 64'd1);
        check("lock_errcnt", 64'(errcnt_a), 64'd0);
        check("lock_expected", 64'(exp_a), 64'd9);
        check("lock_frmcnt", 64'(frmcnt_a), 64'd4);

        // Error then loss
        for (int n = 9; n < 20; n++) frame_a(32'(n), 32'(n));
        check("pre_err_expected", 64'(exp_a), 64'd20);
        frame_a(99, 99);
        check("err_pulse", 64'(error_a), 64'd1);
        check("err_count1", 64'(errcnt_a), 64'd1);
        check("err_lastbad", lastbad_a, 64'h0000_0063_0000_0063);
        check("err_still_locked", 64'(locked_a), 64'd1);
        tick();
        check("err_pulse_end", 64'(error_a), 64'd0);
        frame_a(21, 21);
        check("good_no_err", 64'(error_a), 64'd0);
        frame_a(99, 99);
        frame_a(99, 99);
        check("loss_after_2", 64'(locked_a), 64'd1);
        frame_a(99, 99);
        check("loss_after_3", 64'(locked_a), 64'd0);
        check("loss_errcnt", 64'(errcnt_a), 64'd4);

        // Half mismatch in SEEK is silent; in LOCKED it is an error
        frame_a(32'h10, 32'h11);
        check("seek_mismatch_err", 64'(error_a), 64'd0);
        check("seek_mismatch_cnt", 64'(errcnt_a), 64'd4);
        for (int n = 12; n < 16; n++) frame_a(32'(n), 32'(n));
        check("relock", 64'(locked_a), 64'd1);
        check("relock_expected", 64'(exp_a), 64'h10);
        frame_a(32'h10, 32'h11);
        check("lock_mismatch_err", 64'(error_a), 64'd1);
        check("lock_mismatch_cnt", 64'(errcnt_a), 64'd5);
        check("lock_mismatch_last", lastbad_a, 64'h0000_0010_0000_0011);

        // Mid-operation reset, then wrap-around
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_locked", 64'(locked_a), 64'd0);
        check("mid_rst_expected", 64'(exp_a), 64'd0);
        check("mid_rst_errcnt", 64'(errcnt_a), 64'd0);
        check("mid_rst_lastbad", lastbad_a, 64'd0);
        tick();
        frame_a(32'hFFFF_FFFD, 32'hFFFF_FFFD);
        frame_a(32'hFFFF_FFFE, 32'hFFFF_FFFE);
        frame_a(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        frame_a(32'h0, 32'h0);
        check("wrap_locked", 64'(locked_a), 64'd1);
        check("wrap_expected1", 64'(exp_a), 64'd1);
        frame_a(1, 1);
        check("wrap_no_err", 64'(error_a), 64'd0);
        check("wrap_expected2", 64'(exp_a), 64'd2);

        // Link drop: the frame in the falling cycle is ignored
        ready_a = 1'b0;
        frame_a(2, 2);
        check("drop_locked", 64'(locked_a), 64'd0);
        check("drop_frmcnt", 64'(frmcnt_a), 64'd5);
        check("drop_expected", 64'(exp_a), 64'd2);
        frame_a(2, 2);
        check("drop_ignored", 64'(frmcnt_a), 64'd5);
        ready_a = 1'b1;
        tick();
        frame_a(40, 40);
        frame_a(41, 41);
        frame_a(42, 42);
        check("reacq_before", 64'(locked_a), 64'd0);
        frame_a(43, 43);
        check("reacq_locked", 64'(locked_a), 64'd1);
        check("reacq_errcnt", 64'(errcnt_a), 64'd0);

        // Clear leaves state and expected alone
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check("clr_frmcnt", 64'(frmcnt_a), 64'd0);
        check("clr_locked", 64'(locked_a), 64'd1);
        check("clr_expected", 64'(exp_a), 64'd44);
        clear_a = 1'b1;
        frame_a(44, 44);
        clear_a = 1'b0;
        check("clr_good_frmcnt", 64'(frmcnt_a), 64'd1);
        check("clr_good_errcnt", 64'(errcnt_a), 64'd0);

        // Saturation on the 4-bit instance
        ready_b = 1'b1;
        tick();
        frame_b(100, 100);
        check("b_lock1", 64'(locked_b), 64'd1);
        check("b_expected", 64'(exp_b), 64'd101);
        for (int i = 0; i < 20; i++) frame_b(0, 0);
        check("b_sat", 64'(errcnt_b), 64'd15);
        check("b_still_locked", 64'(locked_b), 64'd1);
        check("b_frmcnt", 64'(frmcnt_b), 64'd21);
        clear_b = 1'b1;
        frame_b(7, 8);
        clear_b = 1'b0;
        check("b_clr_errcnt", 64'(errcnt_b), 64'd1);
        check("b_clr_frmcnt", 64'(frmcnt_b), 64'd1);
        check("b_clr_lastbad", lastbad_b, 64'h0000_0007_0000_0008);
        check("b_clr_err", 64'(error_b), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
